// File: rtl/pseudo_color_bank.sv
// pseudo_color_bank: run-time programmable {gray,detail} -> YUV mapper with frame-synchronous palette banks
module pseudo_color_bank #(
  parameter int    PIXEL_DATA_W = 8,
  parameter int    DETAIL_LUT_W = 3,
  parameter int    Y_DATA_W     = 8,
  parameter int    U_DATA_W     = 8,
  parameter int    V_DATA_W     = 8,
  parameter int    BANK_W       = 2,
  parameter string INIT_FILE    = "",
  localparam int   DATA_LUT_W   = PIXEL_DATA_W + DETAIL_LUT_W,
  localparam int   YUV_DATA_W   = Y_DATA_W + U_DATA_W + V_DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vsync_i,
  input  logic                  data_valid_i,
  input  logic [DATA_LUT_W-1:0] data_lut_i,
  input  logic                  mode_i,
  input  logic [BANK_W-1:0]     bank_sel_i,
  input  logic                  cfg_we_i,
  input  logic [BANK_W-1:0]     cfg_bank_i,
  input  logic [DATA_LUT_W-1:0] cfg_addr_i,
  input  logic [YUV_DATA_W-1:0] cfg_data_i,
  output logic                  data_valid_o,
  output logic [Y_DATA_W-1:0]   y_data_o,
  output logic [U_DATA_W-1:0]   u_data_o,
  output logic [V_DATA_W-1:0]   v_data_o,
  output logic [BANK_W-1:0]     bank_active_o,
  output logic                  mode_active_o
);
  localparam int DEPTH = 1 << (BANK_W + DATA_LUT_W);
  localparam logic [U_DATA_W-1:0] U_MID = {1'b1, {(U_DATA_W-1){1'b0}}};
  localparam logic [V_DATA_W-1:0] V_MID = {1'b1, {(V_DATA_W-1){1'b0}}};
  logic [YUV_DATA_W-1:0] mem [0:DEPTH-1];
  logic [YUV_DATA_W-1:0] rd_q;
  logic [PIXEL_DATA_W-1:0] gray;
  logic [Y_DATA_W-1:0] gray_y;
  logic mode_d, mode_q, v1_d, v1_q, mode1_d, mode1_q, v2_d, v2_q;
  logic [BANK_W-1:0] bank_d, bank_q;
  logic [Y_DATA_W-1:0] gray1_d, gray1_q, y_d, y_q;
  logic [U_DATA_W-1:0] u_d, u_q;
  logic [V_DATA_W-1:0] v_d, v_q;
  assign gray = data_lut_i[DATA_LUT_W-1:DETAIL_LUT_W];
  if (Y_DATA_W >= PIXEL_DATA_W) begin : g_widen
    assign gray_y = Y_DATA_W'(gray) << (Y_DATA_W - PIXEL_DATA_W);
  end else begin : g_trunc
    assign gray_y = gray[PIXEL_DATA_W-1 -: Y_DATA_W];
  end
  always_ff @(posedge clk_i) begin
    if (cfg_we_i) mem[{cfg_bank_i, cfg_addr_i}] <= cfg_data_i;
    rd_q <= mem[{bank_q, data_lut_i}];
  end
  always_comb begin
    mode_d  = vsync_i ? mode_i : mode_q;
    bank_d  = vsync_i ? bank_sel_i : bank_q;
    v1_d    = data_valid_i;
    mode1_d = mode_q;
    gray1_d = gray_y;
    v2_d    = v1_q;
    y_d     = v1_q ? (mode1_q ? rd_q[YUV_DATA_W-1 -: Y_DATA_W] : gray1_q) : y_q;
    u_d     = v1_q ? (mode1_q ? rd_q[U_DATA_W+V_DATA_W-1 -: U_DATA_W] : U_MID) : u_q;
    v_d     = v1_q ? (mode1_q ? rd_q[V_DATA_W-1:0] : V_MID) : v_q;
  end
  always_ff @(posedge clk_i) begin
    mode1_q <= mode1_d;
    gray1_q <= gray1_d;
    if (rst_i) begin
      mode_q <= 1'b0;
      bank_q <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      y_q    <= '0;
      u_q    <= '0;
      v_q    <= '0;
    end else begin
      mode_q <= mode_d;
      bank_q <= bank_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      y_q    <= y_d;
      u_q    <= u_d;
      v_q    <= v_d;
    end
  end
  assign data_valid_o  = v2_q;
  assign y_data_o      = y_q;
  assign u_data_o      = u_q;
  assign v_data_o      = v_q;
  assign bank_active_o = bank_q;
  assign mode_active_o = mode_q;
endmodule

// File: tb/tb_pseudo_color_bank.sv
// tb_pseudo_color_bank: directed checks of bypass, palette banks, frame-boundary switching, collision and reset
module tb_pseudo_color_bank;
  logic clk_i, rst_i, vsync_i, data_valid_i, mode_i, cfg_we_i;
  logic [10:0] data_lut_i, cfg_addr_i;
  logic [1:0] bank_sel_i, cfg_bank_i;
  logic [23:0] cfg_data_i;
  logic data_valid_o, mode_active_o;
  logic [7:0] y_data_o, u_data_o, v_data_o;
  logic [1:0] bank_active_o;
  int tests = 0;
  int fails = 0;
  pseudo_color_bank dut (
    .clk_i(clk_i), .rst_i(rst_i), .vsync_i(vsync_i), .data_valid_i(data_valid_i),
    .data_lut_i(data_lut_i), .mode_i(mode_i), .bank_sel_i(bank_sel_i),
    .cfg_we_i(cfg_we_i), .cfg_bank_i(cfg_bank_i), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .data_valid_o(data_valid_o), .y_data_o(y_data_o),
    .u_data_o(u_data_o), .v_data_o(v_data_o), .bank_active_o(bank_active_o),
    .mode_active_o(mode_active_o)
  );
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_yuv(input string tag, input logic [23:0] exp);
    chk({tag, "_valid"}, 32'(data_valid_o), 32'd1);
    chk({tag, "_y"}, 32'(y_data_o), 32'(exp[23:16]));
    chk({tag, "_u"}, 32'(u_data_o), 32'(exp[15:8]));
    chk({tag, "_v"}, 32'(v_data_o), 32'(exp[7:0]));
  endtask
  task automatic cfg_write(input logic [1:0] b, input logic [10:0] a, input logic [23:0] d);
    cfg_we_i = 1'b1; cfg_bank_i = b; cfg_addr_i = a; cfg_data_i = d;
    tick;
    cfg_we_i = 1'b0;
  endtask
  task automatic frame(input logic m, input logic [1:0] b);
    vsync_i = 1'b1; mode_i = m; bank_sel_i = b;
    tick;
    vsync_i = 1'b0;
  endtask
  task automatic pixel(input logic [10:0] idx);
    data_valid_i = 1'b1; data_lut_i = idx;
    tick;
    data_valid_i = 1'b0;
    tick;
  endtask
  initial begin
    rst_i = 1'b1; vsync_i = 1'b0; data_valid_i = 1'b0; data_lut_i = '0; mode_i = 1'b0;
    bank_sel_i = '0; cfg_we_i = 1'b0; cfg_bank_i = '0; cfg_addr_i = '0; cfg_data_i = '0;
    tick;
    tick;
    rst_i = 1'b0;
    chk("rst_valid", 32'(data_valid_o), 32'd0);
    chk("rst_y", 32'(y_data_o), 32'd0);
    chk("rst_u", 32'(u_data_o), 32'd0);
    chk("rst_v", 32'(v_data_o), 32'd0);
    chk("rst_bank", 32'(bank_active_o), 32'd0);
    chk("rst_mode", 32'(mode_active_o), 32'd0);
    pixel(11'h5A3);
    chk_yuv("bypass", 24'hB48080);
    tick;
    chk("bypass_valid_drop", 32'(data_valid_o), 32'd0);
    cfg_write(2'd1, 11'h010, 24'h123456);
    frame(1'b1, 2'd1);
    chk("pal_bank", 32'(bank_active_o), 32'd1);
    chk("pal_mode", 32'(mode_active_o), 32'd1);
    pixel(11'h010);
    chk_yuv("pal", 24'h123456);
    cfg_write(2'd0, 11'h005, 24'hAAAAAA);
    cfg_write(2'd2, 11'h005, 24'h555555);
    frame(1'b1, 2'd2);
    pixel(11'h005);
    chk_yuv("iso_b2", 24'h555555);
    frame(1'b1, 2'd0);
    pixel(11'h005);
    chk_yuv("iso_b0", 24'hAAAAAA);
    data_valid_i = 1'b1; data_lut_i = 11'h005; bank_sel_i = 2'd2;
    tick;
    chk("mid_frame_bank", 32'(bank_active_o), 32'd0);
    vsync_i = 1'b1;
    tick;
    vsync_i = 1'b0;
    chk_yuv("fb_before", 24'hAAAAAA);
    chk("fb_bank_new", 32'(bank_active_o), 32'd2);
    tick;
    data_valid_i = 1'b0;
    chk_yuv("fb_vsync_pix", 24'hAAAAAA);
    tick;
    chk_yuv("fb_after", 24'h555555);
    tick;
    cfg_write(2'd2, 11'h005, 24'h111111);
    cfg_we_i = 1'b1; cfg_bank_i = 2'd2; cfg_addr_i = 11'h005; cfg_data_i = 24'h00FF00;
    data_valid_i = 1'b1; data_lut_i = 11'h005;
    tick;
    cfg_we_i = 1'b0;
    tick;
    data_valid_i = 1'b0;
    chk_yuv("coll_old", 24'h111111);
    tick;
    chk_yuv("coll_new", 24'h00FF00);
    data_valid_i = 1'b1; data_lut_i = 11'h005;
    tick;
    tick;
    data_valid_i = 1'b0;
    rst_i = 1'b1; vsync_i = 1'b1; mode_i = 1'b1; bank_sel_i = 2'd3;
    tick;
    rst_i = 1'b0; vsync_i = 1'b0;
    chk("mid_rst_valid", 32'(data_valid_o), 32'd0);
    chk("mid_rst_bank", 32'(bank_active_o), 32'd0);
    chk("mid_rst_mode", 32'(mode_active_o), 32'd0);
    tick;
    chk("mid_rst_flush", 32'(data_valid_o), 32'd0);
    frame(1'b1, 2'd2);
    pixel(11'h005);
    chk_yuv("keep_b2", 24'h00FF00);
    frame(1'b1, 2'd1);
    pixel(11'h010);
    chk_yuv("keep_b1", 24'h123456);
    frame(1'b0, 2'd1);
    pixel(11'h7FF);
    chk_yuv("bypass_max", 24'hFF8080);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
